pll_reset_ctrl: RTL and testbench
=================================

// Module: pll_reset_ctrl
// PURPOSE
//  Reset sequencer and lock supervisor for simple_pll, sitting on the PLL's control side: drives the PLL
//  reset (rst) and consumes its locked output. It holds design reset (sys_rst) until lock has been
//  continuously stable, retries acquisition on timeout, re-acquires on loss of lock and counts lock losses.
// PARAMETERS
//  HOLD_CYCLES    24     refclk cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT   24000  max refclk cycles in WAIT_LOCK before a retry (>=2)
//  STABLE_CYCLES  240    consecutive synchronized-locked cycles required before release (>=1)
//  MAX_RETRIES    7      timeouts tolerated per acquisition before FAIL; must fit RETRY_W
//  CNT_W          16     width of the shared cycle counter; must hold max(HOLD,TIMEOUT,STABLE)
//  RETRY_W        3      retry_count width
//  LOST_W         8      lost_count width
// PORTS
//  refclk       in   1        PLL reference clock; the only clock
//  rst          in   1        asynchronous, active-high reset
//  locked       in   1        PLL locked, asynchronous to refclk
//  reset_req    in   1        1-cycle software request to re-run the PLL reset sequence
//  pll_rst      out  1        to PLL rst; registered
//  sys_rst      out  1        design reset, active-high; registered
//  ready        out  1        ~sys_rst; high only in RUN
//  fail         out  1        high only in FAIL
//  state        out  3        current state encoding (debug)
//  retry_count  out  RETRY_W  timeouts during current acquisition
//  lost_count   out  LOST_W   RUN->lock-loss events; saturates at all-ones
// BEHAVIOUR
//  - locked passes a 2-flop synchronizer -> locked_s (2 edge latency). All outputs are registered.
//  - Reset values: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fail=0, counters=0, cnt=0.
//  - States:
//    RESET_PLL: pll_rst=1, sys_rst=1; cnt counts 0..HOLD_CYCLES-1, then -> WAIT_LOCK with cnt=0
//      (pll_rst high exactly HOLD_CYCLES cycles).
//    WAIT_LOCK: pll_rst=0, sys_rst=1. On locked_s=1 -> STABLE with cnt=0. When cnt==LOCK_TIMEOUT-1:
//      if retry_count==MAX_RETRIES -> FAIL; otherwise retry_count++ and -> RESET_PLL.
//    STABLE: locked_s=0 -> WAIT_LOCK (cnt=0; timeout restarts). When cnt==STABLE_CYCLES-1 with locked_s=1
//      -> RUN, retry_count cleared. sys_rst falls on edge STABLE_CYCLES+3, counting the first refclk edge
//      after locked rises as edge 1.
//    RUN: sys_rst=0, ready=1. locked_s=0 -> RESET_PLL; sys_rst=1 and pll_rst=1 on the same edge;
//      lost_count++ (saturating).
//    FAIL: pll_rst=1, sys_rst=1, fail=1. Left only via rst or reset_req.
//  - reset_req is priority 2 (after rst) in every state: -> RESET_PLL, cnt=0, retry_count=0, fail=0.
//    In RUN, reset_req together with locked_s=0: reset_req wins and lost_count is NOT incremented.
//  - A locked glitch shorter than 2 cycles may be missed; any locked_s low in STABLE restarts qualification.
//  - Asserting rst mid-sequence returns everything to reset values immediately (async); the sequence
//    restarts from RESET_PLL after release.
//  - Unused state encodings -> RESET_PLL.
// STRUCTURE
//  - pll_reset_ctrl_defs.vh: state localparams (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).
//  - Sub-module sync_2ff (1-bit, async-reset-to-0 synchronizer) for locked; all else in one always block
//    plus next-state logic.
// TESTING (HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2)
//  - rst release; locked rises 5 cycles after pll_rst falls and stays -> pll_rst high exactly 4 cycles;
//    sys_rst falls and ready rises on edge 11 after locked rises; retry_count=0.
//  - locked never rises -> two retries (retry_count 1, then 2), each with a 4-cycle pll_rst pulse;
//    third timeout -> FAIL, fail=1, pll_rst=1; reset_req -> RESET_PLL, fail=0, retry_count=0.
//  - In STABLE, locked drops for 3 cycles at cnt=5 -> back to WAIT_LOCK; sys_rst stays 1;
//    release requires a fresh 8-cycle run.
//  - In RUN, locked drops -> sys_rst=1 within 3 edges, lost_count 0->1, full reacquisition;
//    force 256 losses with LOST_W=8 -> lost_count holds 255.
//  - In RUN, reset_req and locked fall on the same edge -> RESET_PLL, lost_count unchanged.
//  - rst asserted in WAIT_LOCK, STABLE and RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pll_reset_ctrl_pkg;

   localparam int STATE_W = 3;

   // Encodings are visible on the debug state port, so they are fixed.
   typedef enum logic [STATE_W-1:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   // The PLL is held in reset while pulsing it and while parked after giving up.
   function automatic logic pll_rst_for(input state_t s);
      return (s == ST_RESET_PLL) || (s == ST_FAIL);
   endfunction

   // The design is only let out of reset once lock has been qualified.
   function automatic logic sys_rst_for(input state_t s);
      return (s != ST_RUN);
   endfunction

   function automatic logic fail_for(input state_t s);
      return (s == ST_FAIL);
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// Control-side bundle between the reset sequencer and its PLL/system.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface pll_reset_ctrl_if
   import pll_reset_ctrl_pkg::*;
#(
   parameter int RETRY_W = 3,
   parameter int LOST_W  = 8
) ();

   logic               locked;
   logic               reset_req;
   logic               pll_rst;
   logic               sys_rst;
   logic               ready;
   logic               fail;
   logic [STATE_W-1:0] state;
   logic [RETRY_W-1:0] retry_count;
   logic [LOST_W-1:0]  lost_count;

   // Sequencer side.
   modport master (
      input  locked, reset_req,
      output pll_rst, sys_rst, ready, fail, state, retry_count, lost_count
   );

   // PLL / software / system side.
   modport slave (
      output locked, reset_req,
      input  pll_rst, sys_rst, ready, fail, state, retry_count, lost_count
   );

endinterface

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous level into the refclk domain.
// Latency: 2 refclk edges from input change to q.
// Backpressure: none.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Both stages clear to 0 so "locked" reads as not-locked coming out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses pll_rst, qualifies lock, releases sys_rst.
// Latency: locked->sys_rst release after STABLE_CYCLES+3 edges; loss of lock -> sys_rst within 3 edges.
// Backpressure: none; reset_req is a 1-cycle pulse honoured in every state.
module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES   = 24,
   parameter int LOCK_TIMEOUT  = 24000,
   parameter int STABLE_CYCLES = 240,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16,
   parameter int RETRY_W       = 3,
   parameter int LOST_W        = 8
) (
   input  logic              refclk,
   input  logic              rst,
   pll_reset_ctrl_if.master  bus
);

   // Terminal values of the single shared cycle counter, one per timed state.
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
   localparam logic [LOST_W-1:0]  LOST_SAT     = {LOST_W{1'b1}};

   logic               locked_s;

   state_t             state_q;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_nxt;
   logic [LOST_W-1:0]  lost_q;
   logic [LOST_W-1:0]  lost_nxt;

   logic               pll_rst_q;
   logic               sys_rst_q;
   logic               ready_q;
   logic               fail_q;

   // locked comes straight from the PLL analog block and is not refclk-aligned.
   sync_2ff u_sync_locked (
      .clk (refclk),
      .rst (rst),
      .d   (bus.locked),
      .q   (locked_s)
   );

   // Next-state, counter and event bookkeeping; reset_req overrides every state.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      retry_nxt = retry_q;
      lost_nxt  = lost_q;

      if (bus.reset_req) begin
         // Software restart wins even over a coincident lock loss in RUN,
         // so that event is deliberately not counted as a loss.
         state_nxt = ST_RESET_PLL;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state_q)
            ST_RESET_PLL: begin
               if (cnt_q == HOLD_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end

            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_nxt = ST_STABLE;
                  cnt_nxt   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  cnt_nxt = '0;
                  if (retry_q == RETRY_LIMIT) begin
                     state_nxt = ST_FAIL;
                  end else begin
                     state_nxt = ST_RESET_PLL;
                     retry_nxt = retry_q + RETRY_W'(1);
                  end
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end

            ST_STABLE: begin
               // Any dropout restarts qualification and gives the lock timeout a fresh window.
               if (!locked_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end

            ST_RUN: begin
               if (!locked_s) begin
                  state_nxt = ST_RESET_PLL;
                  cnt_nxt   = '0;
                  if (lost_q != LOST_SAT) begin
                     lost_nxt = lost_q + LOST_W'(1);
                  end
               end
            end

            ST_FAIL: begin
               cnt_nxt = '0;
            end

            default: begin
               state_nxt = ST_RESET_PLL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State register plus registered outputs decoded from the state being entered,
   // so pll_rst/sys_rst change on the same edge as the state itself.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= '0;
         lost_q    <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         retry_q   <= retry_nxt;
         lost_q    <= lost_nxt;
         pll_rst_q <= pll_rst_for(state_nxt);
         sys_rst_q <= sys_rst_for(state_nxt);
         ready_q   <= ~sys_rst_for(state_nxt);
         fail_q    <= fail_for(state_nxt);
      end
   end

   assign bus.pll_rst     = pll_rst_q;
   assign bus.sys_rst     = sys_rst_q;
   assign bus.ready       = ready_q;
   assign bus.fail        = fail_q;
   assign bus.state       = state_q;
   assign bus.retry_count = retry_q;
   assign bus.lost_count  = lost_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: vector table, hand sequences and randomized lock traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_reset_ctrl;

   localparam int HOLD    = 4;
   localparam int TIMEOUT = 20;
   localparam int STABLE  = 8;
   localparam int MAXR    = 2;

   localparam int PH_RESET  = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAIL   = 4;

   logic refclk;
   logic rst;

   pll_reset_ctrl_if #(.RETRY_W(3), .LOST_W(8)) bus ();

   pll_reset_ctrl #(
      .HOLD_CYCLES   (HOLD),
      .LOCK_TIMEOUT  (TIMEOUT),
      .STABLE_CYCLES (STABLE),
      .MAX_RETRIES   (MAXR),
      .CNT_W         (16),
      .RETRY_W       (3),
      .LOST_W        (8)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   int total;
   int bad;

   // Reference model: phase + time spent in phase, plus the two synchronizer samples.
   logic m_s1, m_s2;
   int   m_ph, m_age, m_retry, m_lost;

   typedef struct {
      logic lk;
      logic rq;
      int   n;
      int   st;
      logic pr;
      logic sr;
      logic rd;
      logic fl;
      int   rc;
      int   lc;
   } vec_t;

   vec_t vt[19];

   function automatic logic [31:0] exp_pack(input int st, input logic pr, input logic sr,
                                            input logic rd, input logic fl, input int rc, input int lc);
      return {14'd0, st[2:0], pr, sr, rd, fl, rc[2:0], lc[7:0]};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {14'd0, bus.state, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail,
              bus.retry_count, bus.lost_count};
   endfunction

   function automatic logic [31:0] model_vec();
      return exp_pack(m_ph, (m_ph == PH_RESET) || (m_ph == PH_FAIL), m_ph != PH_RUN,
                      m_ph == PH_RUN, m_ph == PH_FAIL, m_retry, m_lost);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_ph = PH_RESET; m_age = 0; m_retry = 0; m_lost = 0;
   endtask

   task automatic model_step(input logic lk, input logic rq);
      logic ls;
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      if (rq) begin
         m_ph = PH_RESET; m_age = 0; m_retry = 0;
      end else begin
         case (m_ph)
            PH_RESET: begin
               m_age++;
               if (m_age == HOLD) begin m_ph = PH_WAIT; m_age = 0; end
            end
            PH_WAIT: begin
               if (ls) begin
                  m_ph = PH_STABLE; m_age = 0;
               end else begin
                  m_age++;
                  if (m_age == TIMEOUT) begin
                     m_age = 0;
                     if (m_retry == MAXR) m_ph = PH_FAIL;
                     else begin m_ph = PH_RESET; m_retry++; end
                  end
               end
            end
            PH_STABLE: begin
               if (!ls) begin
                  m_ph = PH_WAIT; m_age = 0;
               end else begin
                  m_age++;
                  if (m_age == STABLE) begin m_ph = PH_RUN; m_age = 0; m_retry = 0; end
               end
            end
            PH_RUN: begin
               if (!ls) begin
                  m_ph = PH_RESET; m_age = 0;
                  if (m_lost < 255) m_lost++;
               end
            end
            default: ;
         endcase
      end
   endtask

   // One refclk cycle: drive, clock, advance model, compare just after the edge.
   task automatic tick(input logic lk, input logic rq);
      bus.locked    = lk;
      bus.reset_req = rq;
      @(posedge refclk);
      model_step(lk, rq);
      #1;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic ticks(input int n, input logic lk);
      for (int k = 0; k < n; k++) tick(lk, 1'b0);
   endtask

   // Assert rst between edges and expect every output back at reset value before the next edge.
   task automatic rst_pulse(input string nm);
      #3 rst = 1'b1;
      #1;
      check(nm, dut_vec(), exp_pack(PH_RESET, 1, 1, 0, 0, 0, 0));
      model_reset();
      bus.locked = 1'b0;
      @(posedge refclk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int lvl, len;
      logic rq;
      total = 0;
      bad   = 0;

      //          lk  rq  n   st pr sr rd fl rc lc
      vt[0]  = '{1'b0, 1'b0, 3,  0, 1, 1, 0, 0, 0, 0};  // still pulsing pll_rst
      vt[1]  = '{1'b0, 1'b0, 1,  1, 0, 1, 0, 0, 0, 0};  // pll_rst high exactly 4 cycles
      vt[2]  = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 0, 0, 0};
      vt[3]  = '{1'b1, 1'b0, 2,  1, 0, 1, 0, 0, 0, 0};  // synchronizer delay
      vt[4]  = '{1'b1, 1'b0, 1,  2, 0, 1, 0, 0, 0, 0};
      vt[5]  = '{1'b1, 1'b0, 7,  2, 0, 1, 0, 0, 0, 0};  // edge 10: still held
      vt[6]  = '{1'b1, 1'b0, 1,  3, 0, 0, 1, 0, 0, 0};  // edge 11: released
      vt[7]  = '{1'b0, 1'b0, 2,  3, 0, 0, 1, 0, 0, 0};
      vt[8]  = '{1'b0, 1'b0, 1,  0, 1, 1, 0, 0, 0, 1};  // loss seen on 3rd edge
      vt[9]  = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 0, 0, 1};
      vt[10] = '{1'b0, 1'b0, 20, 0, 1, 1, 0, 0, 1, 1};  // first timeout
      vt[11] = '{1'b0, 1'b0, 3,  0, 1, 1, 0, 0, 1, 1};
      vt[12] = '{1'b0, 1'b0, 1,  1, 0, 1, 0, 0, 1, 1};
      vt[13] = '{1'b0, 1'b0, 20, 0, 1, 1, 0, 0, 2, 1};  // second timeout
      vt[14] = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 0, 2, 1};
      vt[15] = '{1'b0, 1'b0, 19, 1, 0, 1, 0, 0, 2, 1};
      vt[16] = '{1'b0, 1'b0, 1,  4, 1, 1, 0, 1, 2, 1};  // third timeout -> give up
      vt[17] = '{1'b0, 1'b0, 5,  4, 1, 1, 0, 1, 2, 1};
      vt[18] = '{1'b0, 1'b1, 1,  0, 1, 1, 0, 0, 0, 1};  // reset_req leaves the parked state

      rst = 1'b1;
      bus.locked    = 1'b0;
      bus.reset_req = 1'b0;
      model_reset();
      repeat (2) @(posedge refclk);
      #1;
      check("reset_vals", dut_vec(), exp_pack(PH_RESET, 1, 1, 0, 0, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         for (int k = 0; k < vt[i].n; k++) tick(vt[i].lk, vt[i].rq);
         check($sformatf("vec%0d", i), dut_vec(),
               exp_pack(vt[i].st, vt[i].pr, vt[i].sr, vt[i].rd, vt[i].fl, vt[i].rc, vt[i].lc));
      end

      // Dropout during qualification forces a fresh full stable window.
      ticks(4, 1'b0);
      ticks(3, 1'b1);
      ticks(5, 1'b1);
      check("stable_cnt5", dut_vec(), exp_pack(PH_STABLE, 0, 1, 0, 0, 0, 1));
      ticks(3, 1'b0);
      check("glitch_back_wait", dut_vec(), exp_pack(PH_WAIT, 0, 1, 0, 0, 0, 1));
      ticks(2, 1'b1);
      ticks(1, 1'b1);
      check("requalify", dut_vec(), exp_pack(PH_STABLE, 0, 1, 0, 0, 0, 1));
      ticks(7, 1'b1);
      check("no_early_release", dut_vec(), exp_pack(PH_STABLE, 0, 1, 0, 0, 0, 1));
      ticks(1, 1'b1);
      check("release_fresh", dut_vec(), exp_pack(PH_RUN, 0, 0, 1, 0, 0, 1));

      // reset_req coinciding with the synchronized lock loss: not counted.
      ticks(2, 1'b0);
      tick(1'b0, 1'b1);
      check("req_beats_loss", dut_vec(), exp_pack(PH_RESET, 1, 1, 0, 0, 0, 1));

      // Drive 256 more losses and expect the counter pinned at all-ones.
      for (int l = 0; l < 256; l++) begin
         for (int k = 0; k < 40 && bus.state != 3'd3; k++) tick(1'b1, 1'b0);
         for (int k = 0; k < 10 && bus.state != 3'd0; k++) tick(1'b0, 1'b0);
      end
      check("lost_sat", {24'd0, bus.lost_count}, 32'd255);

      // Asynchronous reset from WAIT_LOCK, STABLE and RUN.
      ticks(5, 1'b0);
      check("pre_rst_wait", {29'd0, bus.state}, 32'd1);
      rst_pulse("rst_in_wait");
      ticks(6, 1'b1);
      check("pre_rst_stable", {29'd0, bus.state}, 32'd2);
      rst_pulse("rst_in_stable");
      ticks(13, 1'b1);
      check("pre_rst_run", {29'd0, bus.state}, 32'd3);
      rst_pulse("rst_in_run");

      // Randomized lock traffic with occasional software restarts.
      for (int r = 0; r < 120; r++) begin
         lvl = $urandom_range(0, 1);
         len = $urandom_range(1, 60);
         for (int k = 0; k < len; k++) begin
            rq = ($urandom_range(0, 199) == 0);
            tick(lvl[0], rq);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
